rv32_load_store_unit: RTL and testbench
=======================================

Name: rv32_load_store_unit

Overview:
- Sits between the multicycle core's data-memory port and a word-addressed synchronous RAM bank.
- Accepts byte, halfword and word loads and stores over a valid/ready request handshake.
- Performs lane extraction and sign or zero extension on loads.
- Performs read-modify-write for sub-word stores.
- Flags misaligned and out-of-bank accesses and returns them as exceptions instead of touching the RAM.

Parameters:
- DEPTH, 1024: RAM size in 32-bit words; must be a power of 2.
- BANK, 4'h1: required value of req_addr[31:28] for the access to be legal.
- L, $clog2(DEPTH): RAM word-address width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_addr  in  32  byte address
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1
- req_wr_data  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rd_data  out  32  extended load data; 0 for stores and exceptions
- rsp_exception  out  2  [0] misaligned or illegal size, [1] out of bank or range
- ram_addr  out  L  RAM word address
- ram_wr_data  out  32  RAM write data
- ram_wr_ena  out  1  RAM write strobe
- ram_rd_data  in  32  RAM read data, valid the cycle after ram_addr is presented with ram_wr_ena=0

Interface decisions:
- Reset rst, synchronous, active-high; clock clk.

Behaviour:
- States: S_IDLE, S_READ, S_MODIFY, S_WRITE, S_RESP.
- Reset: state goes to S_IDLE. rsp_valid=0, rsp_rd_data=0, rsp_exception=0, ram_wr_ena=0, ram_addr=0, all latched request fields=0.
- Reset mid-operation aborts the access. No ram_wr_ena is asserted in the reset cycle or the cycle after it.
- S_IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wr, size, unsigned and wr_data.
  - Compute the exception bits:
    - misaligned = (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | size==11.
    - range = addr[31:28]!=BANK | addr[27:2]>=DEPTH.
  - Next state:
    - any exception bit set: S_RESP;
    - word store: S_WRITE;
    - otherwise: S_READ.
- S_READ: drive ram_addr=addr[L+1:2], ram_wr_ena=0. Next state S_MODIFY.
- S_MODIFY: ram_rd_data is valid this cycle.
  - Load:
    - byte: lane = addr[1:0];
    - half: lane = addr[1] ? [31:16] : [15:0];
    - result is sign-extended unless unsigned; word is passed through.
    - Register the result into rsp_rd_data. Next state S_RESP.
  - Sub-word store:
    - ram_wr_data = ram_rd_data with the selected lane replaced by the low 8 or 16 bits of wr_data.
    - Assert ram_wr_ena=1 at the same ram_addr. Next state S_RESP.
- S_WRITE: ram_addr=word index, ram_wr_data=wr_data, ram_wr_ena=1. Next state S_RESP.
- S_RESP:
  - rsp_valid=1 for exactly one cycle; rsp_rd_data and rsp_exception hold their registered values.
  - No response backpressure. Next state S_IDLE.
- req_ready=0 in all states except S_IDLE. req_valid outside S_IDLE is ignored; the requester must hold it.
- rsp_rd_data and rsp_exception are cleared on acceptance of each new request.
- ram_wr_ena is high only in S_WRITE and in S_MODIFY for stores. In all other cycles ram_wr_data is don't-care.
- Latency from the accept cycle T:
  - exception: rsp_valid at T+1;
  - word store: write at T+1, rsp_valid at T+2;
  - load or sub-word store: read at T+1, extract or write at T+2, rsp_valid at T+3.
- An exception never reads or writes the RAM, and rsp_rd_data=0.
- Back-to-back operation: a new request can be accepted the cycle after rsp_valid.

Test Plan:
- Load word: RAM[0]=32'h8081_82F3; load word at addr 32'h1000_0000 -> rsp_valid at T+3, rsp_rd_data=32'h8081_82F3, exception 0.
- Byte loads, same RAM[0]:
  - signed byte at 32'h1000_0000 -> 32'hFFFF_FFF3;
  - unsigned byte -> 32'h0000_00F3;
  - signed byte at offset 3 -> 32'hFFFF_FF80;
  - signed half at offset 2 -> 32'hFFFF_8081.
- Sub-word store: RAM[1]=32'h1122_3344; store byte 8'hAB at 32'h1000_0005 -> single ram_wr_ena pulse, RAM[1]=32'h1122_AB44; a later word load returns 32'h1122_AB44.
- Word store: store word 32'hDEAD_BEEF at 32'h1000_0008 -> ram_wr_ena exactly at T+1, rsp_valid at T+2, RAM[2]=32'hDEAD_BEEF.
- Exceptions, each -> rsp_valid at T+1, no RAM activity, rsp_rd_data=0:
  - half at 32'h1000_0001 -> exception 2'b01;
  - word at 32'h2000_0000 -> 2'b10;
  - word at byte 4*DEPTH -> 2'b10;
  - req_size=11 -> 2'b01.
- Reset during S_MODIFY of a byte store -> next cycle S_IDLE, RAM unchanged, rsp_valid=0, req_ready=1.

Source files
------------

// File: rtl/rv32_load_store_unit.sv
// Byte/half/word load-store bridge to a word-addressed synchronous RAM; sub-word stores use read-modify-write.
// Latency: exception 1, word store 2, load/sub-word store 3 cycles; one request in flight, req_ready only in S_IDLE.
module rv32_load_store_unit #(
    parameter int         DEPTH = 1024,
    parameter logic [3:0] BANK  = 4'h1,
    parameter int         L     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    input  logic          req_wr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wr_data,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rd_data,
    output logic [1:0]    rsp_exception,
    output logic [L-1:0]  ram_addr,
    output logic [31:0]   ram_wr_data,
    output logic          ram_wr_ena,
    input  logic [31:0]   ram_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MODIFY,
        S_WRITE,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [L-1:0]  r_word;
    logic [1:0]    r_lane;
    logic          r_wr;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [31:0]   r_wr_data;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rd_data;
    logic [1:0]    r_rsp_exception;

    logic          w_misaligned;
    logic          w_range;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_data;
    logic [31:0]   w_merged;

    assign w_misaligned = (req_size == 2'b01 && req_addr[0]) ||
                          (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                          (req_size == 2'b11);
    assign w_range      = (req_addr[31:28] != BANK) ||
                          ({6'd0, req_addr[27:2]} >= 32'(DEPTH));

    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = ram_rd_data[7:0];
            2'd1:    w_byte = ram_rd_data[15:8];
            2'd2:    w_byte = ram_rd_data[23:16];
            default: w_byte = ram_rd_data[31:24];
        endcase
        w_half = r_lane[1] ? ram_rd_data[31:16] : ram_rd_data[15:0];

        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = ram_rd_data;
        endcase

        // Only the addressed lane is replaced; the rest comes back from the RAM read.
        w_merged = ram_rd_data;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wr_data[7:0];
                2'd1:    w_merged[15:8]  = r_wr_data[7:0];
                2'd2:    w_merged[23:16] = r_wr_data[7:0];
                default: w_merged[31:24] = r_wr_data[7:0];
            endcase
        end else if (r_size == 2'b01) begin
            if (r_lane[1])
                w_merged[31:16] = r_wr_data[15:0];
            else
                w_merged[15:0]  = r_wr_data[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_word          <= '0;
            r_lane          <= 2'b00;
            r_wr            <= 1'b0;
            r_size          <= 2'b00;
            r_unsigned      <= 1'b0;
            r_wr_data       <= 32'h0;
            r_rsp_valid     <= 1'b0;
            r_rsp_rd_data   <= 32'h0;
            r_rsp_exception <= 2'b00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_word          <= req_addr[L+1:2];
                        r_lane          <= req_addr[1:0];
                        r_wr            <= req_wr;
                        r_size          <= req_size;
                        r_unsigned      <= req_unsigned;
                        r_wr_data       <= req_wr_data;
                        r_rsp_rd_data   <= 32'h0;
                        r_rsp_exception <= {w_range, w_misaligned};
                        if (w_range || w_misaligned) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else if (req_wr && req_size == 2'b10) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: r_state <= S_MODIFY;
                S_MODIFY: begin
                    if (!r_wr)
                        r_rsp_rd_data <= w_load_data;
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                end
                S_WRITE: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rd_data   = r_rsp_rd_data;
    assign rsp_exception = r_rsp_exception;
    assign ram_addr      = r_word;
    assign ram_wr_data   = (r_state == S_MODIFY) ? w_merged : r_wr_data;
    // Gated by rst so a reset landing in S_MODIFY cannot commit the pending write.
    assign ram_wr_ena    = ~rst & ((r_state == S_WRITE) || (r_state == S_MODIFY && r_wr));

endmodule

// File: tb/tb_rv32_load_store_unit.sv
// Self-checking bench: behavioural synchronous RAM plus a response scoreboard
// holding expected data, exception code and arrival cycle for each request.
module tb_rv32_load_store_unit;

    localparam int DEPTH = 1024;
    localparam int L     = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          req_wr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wr_data;
    logic          rsp_valid;
    logic [31:0]   rsp_rd_data;
    logic [1:0]    rsp_exception;
    logic [L-1:0]  ram_addr;
    logic [31:0]   ram_wr_data;
    logic          ram_wr_ena;
    logic [31:0]   ram_rd_data;

    rv32_load_store_unit #(.DEPTH(DEPTH), .BANK(4'h1)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wr        (req_wr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_wr_data   (req_wr_data),
        .rsp_valid     (rsp_valid),
        .rsp_rd_data   (rsp_rd_data),
        .rsp_exception (rsp_exception),
        .ram_addr      (ram_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_wr_ena    (ram_wr_ena),
        .ram_rd_data   (ram_rd_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_wr_ena)
            mem[ram_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_addr];
    end

    typedef struct {
        logic [31:0] data;
        logic [1:0]  exc;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          wr_cyc = 0;
    logic [L-1:0] wr_addr;
    logic [31:0] wr_dat;

    always @(posedge clk) cyc <= cyc + 1;

    // Response and RAM-write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (ram_wr_ena) begin
            wr_cnt  = wr_cnt + 1;
            wr_cyc  = cyc;
            wr_addr = ram_addr;
            wr_dat  = ram_wr_data;
        end
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rsp at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                vectors += 3;
                if (rsp_rd_data !== e.data) begin
                    miscompares++;
                    $display("FAIL rsp_rd_data got %h want %h", rsp_rd_data, e.data);
                end
                if (rsp_exception !== e.exc) begin
                    miscompares++;
                    $display("FAIL rsp_exception got %b want %b", rsp_exception, e.exc);
                end
                if (cyc !== e.cyc) begin
                    miscompares++;
                    $display("FAIL rsp_latency got cycle %0d want %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic [1:0] exp_exc,
                          input int lat, output int c0);
        int n;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready_idle got %b want 1", req_ready);
        end
        req_valid    = 1'b1;
        req_addr     = addr;
        req_wr       = wr;
        req_size     = size;
        req_unsigned = uns;
        req_wr_data  = wdata;
        c0 = cyc;
        sb.push_back('{exp_data, exp_exc, cyc + lat});
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rsp_timeout got no rsp want rsp within %0d cycles", lat);
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wr = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wr_data = '0;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (req_ready !== 1'b1)      begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0)      begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rd_data !== 32'h0)   begin miscompares++; $display("FAIL reset_rsp_rd_data got %h want 0", rsp_rd_data); end
        if (rsp_exception !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_exception got %b want 0", rsp_exception); end
        if (ram_addr !== '0)         begin miscompares++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        rst = 1'b0;
    endtask

    task automatic test_word_store;
        int c0, w0;
        w0 = wr_cnt;
        do_req(32'h1000_0008, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 2'b00, 2, c0);
        vectors += 4;
        if (wr_cnt - w0 !== 1)          begin miscompares++; $display("FAIL wstore_count got %0d want 1", wr_cnt - w0); end
        if (wr_cyc !== c0 + 1)          begin miscompares++; $display("FAIL wstore_cycle got %0d want %0d", wr_cyc, c0 + 1); end
        if (wr_addr !== 10'd2)          begin miscompares++; $display("FAIL wstore_addr got %0d want 2", wr_addr); end
        if (wr_dat !== 32'hDEAD_BEEF)   begin miscompares++; $display("FAIL wstore_data got %h want deadbeef", wr_dat); end
        do_req(32'h1000_0000, 1'b1, 2'b10, 1'b0, 32'h8081_82F3, 32'h0, 2'b00, 2, c0);
        do_req(32'h1000_0004, 1'b1, 2'b10, 1'b0, 32'h1122_3344, 32'h0, 2'b00, 2, c0);
        do_req(32'h1000_0008, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 2'b00, 3, c0);
    endtask

    task automatic test_loads;
        int c0;
        do_req(32'h1000_0000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h8081_82F3, 2'b00, 3, c0);
        do_req(32'h1000_0000, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFF3, 2'b00, 3, c0);
        do_req(32'h1000_0000, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_00F3, 2'b00, 3, c0);
        do_req(32'h1000_0003, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF80, 2'b00, 3, c0);
        do_req(32'h1000_0002, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFF_8081, 2'b00, 3, c0);
        do_req(32'h1000_0002, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_8081, 2'b00, 3, c0);
        do_req(32'h1000_0001, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF82, 2'b00, 3, c0);
        do_req(32'h1000_0000, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFF_82F3, 2'b00, 3, c0);
    endtask

    task automatic test_subword_store;
        int c0, w0;
        w0 = wr_cnt;
        do_req(32'h1000_0005, 1'b1, 2'b00, 1'b0, 32'h0000_00AB, 32'h0, 2'b00, 3, c0);
        vectors += 4;
        if (wr_cnt - w0 !== 1)        begin miscompares++; $display("FAIL bstore_count got %0d want 1", wr_cnt - w0); end
        if (wr_cyc !== c0 + 2)        begin miscompares++; $display("FAIL bstore_cycle got %0d want %0d", wr_cyc, c0 + 2); end
        if (wr_addr !== 10'd1)        begin miscompares++; $display("FAIL bstore_addr got %0d want 1", wr_addr); end
        if (wr_dat !== 32'h1122_AB44) begin miscompares++; $display("FAIL bstore_data got %h want 1122ab44", wr_dat); end
        do_req(32'h1000_0004, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1122_AB44, 2'b00, 3, c0);
        do_req(32'h1000_000A, 1'b1, 2'b01, 1'b0, 32'h1234_CAFE, 32'h0, 2'b00, 3, c0);
        do_req(32'h1000_0008, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFE_BEEF, 2'b00, 3, c0);
    endtask

    task automatic test_exceptions;
        logic [31:0] addrs [4];
        logic [1:0]  sizes [4];
        logic [1:0]  excs  [4];
        int c0, w0;
        addrs = '{32'h1000_0001, 32'h2000_0000, 32'h1000_0000 + 32'(4 * DEPTH), 32'h1000_0000};
        sizes = '{2'b01, 2'b10, 2'b10, 2'b11};
        excs  = '{2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            w0 = wr_cnt;
            do_req(addrs[i], i[0], sizes[i], 1'b0, 32'hFFFF_FFFF, 32'h0, excs[i], 1, c0);
            vectors++;
            if (wr_cnt !== w0) begin
                miscompares++;
                $display("FAIL exc_no_write[%0d] got %0d writes want 0", i, wr_cnt - w0);
            end
        end
        do_req(32'h1000_0000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h8081_82F3, 2'b00, 3, c0);
    endtask

    task automatic test_back_to_back;
        int c0;
        for (int i = 0; i < 4; i++) begin
            do_req(32'h1000_0010 + 32'(4 * i), 1'b1, 2'b10, 1'b0, 32'hA5A5_0000 + 32'(i), 32'h0, 2'b00, 2, c0);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(32'h1000_0010 + 32'(4 * i), 1'b0, 2'b10, 1'b0, 32'h0, 32'hA5A5_0000 + 32'(i), 2'b00, 3, c0);
        end
    endtask

    task automatic test_reset_mid_op;
        int c0, w0;
        w0 = wr_cnt;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready got %b want 1", req_ready); end
        req_valid = 1'b1; req_addr = 32'h1000_0004; req_wr = 1'b1;
        req_size = 2'b00; req_unsigned = 1'b0; req_wr_data = 32'h0000_0055;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (ram_wr_ena !== 1'b0) begin miscompares++; $display("FAIL rmid_wr_in_reset got %b want 0", ram_wr_ena); end
        @(negedge clk);
        rst = 1'b0;
        vectors += 3;
        if (req_ready !== 1'b1)  begin miscompares++; $display("FAIL rmid_idle_ready got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0)  begin miscompares++; $display("FAIL rmid_rsp_valid got %b want 0", rsp_valid); end
        if (ram_wr_ena !== 1'b0) begin miscompares++; $display("FAIL rmid_wr_after got %b want 0", ram_wr_ena); end
        @(negedge clk);
        vectors++;
        if (wr_cnt !== w0) begin miscompares++; $display("FAIL rmid_writes got %0d want 0", wr_cnt - w0); end
        do_req(32'h1000_0004, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1122_AB44, 2'b00, 3, c0);
    endtask

    initial begin
        test_reset;
        test_word_store;
        test_loads;
        test_subword_store;
        test_exceptions;
        test_back_to_back;
        test_reset_mid_op;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got hang want completion");
        $fatal(1);
    end

endmodule
